uart_cmd_ctrl: RTL

Command-frame controller behind the UART receiver. Consumes the received byte stream (`rx_data`/`rx_ready`), frames fixed-length 5-byte commands (sync, opcode, address, data, checksum), validates them, and issues single register read/write requests on a valid/ready handshake toward the register bank. Oversampling baud ticks drive an inter-byte timeout that resynchronises the parser after a broken frame.

---
 rtl/uart_cmd_ctrl_if.sv | 14 +
 rtl/uart_cmd_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Command request bus from the UART frame parser to the register bank.
// The master raises cmd_valid with stable fields until the bank returns cmd_ready.
interface uart_cmd_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;

   modport master (output cmd_valid, output cmd_write, output cmd_addr, output cmd_wdata,
                   input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_write, input  cmd_addr, input  cmd_wdata,
                   output cmd_ready);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frames 5-byte UART commands (sync, op, addr, data, xor checksum) and issues
// one register read/write per valid frame; baud ticks abort stalled frames.
module uart_cmd_ctrl #(
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
   parameter logic [15:0] TIMEOUT_TICKS = 16'd800
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  baud8_tick,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   uart_cmd_ctrl_if.master       cmd,
   output logic                  busy,
   output logic                  err_frame,
   output logic                  err_checksum,
   output logic                  err_timeout,
   output logic                  err_overrun
);

   localparam logic [7:0] OP_READ  = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OP,
      S_ADDR,
      S_DATA,
      S_CHK,
      S_ISSUE
   } state_t;

   state_t      state;
   logic        rx_ready_q;
   logic [15:0] tcnt;
   logic        accept;
   logic [7:0]  exp_chk;

   // rx_ready is a level that may last many cycles, so only its rising edge counts.
   assign accept  = rx_ready && !rx_ready_q;
   // The opcode is fully captured by cmd_write, so it need not be stored separately.
   assign exp_chk = {7'd0, cmd.cmd_write} ^ cmd.cmd_addr ^ cmd.cmd_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         rx_ready_q    <= 1'b0;
         tcnt          <= '0;
         cmd.cmd_valid <= 1'b0;
         cmd.cmd_write <= 1'b0;
         cmd.cmd_addr  <= 8'h00;
         cmd.cmd_wdata <= 8'h00;
         busy          <= 1'b0;
         err_frame     <= 1'b0;
         err_checksum  <= 1'b0;
         err_timeout   <= 1'b0;
         err_overrun   <= 1'b0;
      end else begin
         rx_ready_q   <= rx_ready;
         err_frame    <= 1'b0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
         case (state)
            S_IDLE: begin
               tcnt <= '0;
               if (accept && rx_data == SYNC_BYTE) begin
                  state <= S_OP;
                  busy  <= 1'b1;
               end
            end
            S_OP, S_ADDR, S_DATA, S_CHK: begin
               // A byte landing on the final tick wins over the timeout.
               if (accept) begin
                  tcnt <= '0;
                  case (state)
                     S_OP: begin
                        if (rx_data == OP_READ || rx_data == OP_WRITE) begin
                           cmd.cmd_write <= rx_data[0];
                           state         <= S_ADDR;
                        end else begin
                           err_frame <= 1'b1;
                           busy      <= 1'b0;
                           state     <= S_IDLE;
                        end
                     end
                     S_ADDR: begin
                        cmd.cmd_addr <= rx_data;
                        state        <= S_DATA;
                     end
                     S_DATA: begin
                        cmd.cmd_wdata <= rx_data;
                        state         <= S_CHK;
                     end
                     default: begin
                        if (rx_data == exp_chk) begin
                           cmd.cmd_valid <= 1'b1;
                           state         <= S_ISSUE;
                        end else begin
                           err_checksum <= 1'b1;
                           busy         <= 1'b0;
                           state        <= S_IDLE;
                        end
                     end
                  endcase
               end else if (baud8_tick) begin
                  if (tcnt == TIMEOUT_TICKS - 16'd1) begin
                     tcnt        <= '0;
                     err_timeout <= 1'b1;
                     busy        <= 1'b0;
                     state       <= S_IDLE;
                  end else begin
                     tcnt <= tcnt + 16'd1;
                  end
               end
            end
            S_ISSUE: begin
               tcnt <= '0;
               if (accept) begin
                  err_overrun <= 1'b1;
               end
               if (cmd.cmd_ready) begin
                  cmd.cmd_valid <= 1'b0;
                  busy          <= 1'b0;
                  state         <= S_IDLE;
               end
            end
            default: begin
               cmd.cmd_valid <= 1'b0;
               busy          <= 1'b0;
               tcnt          <= '0;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule
